sram_arb_ctrl: RTL and testbench



---
 rtl/sram_arb_if.sv | 39 +++
 rtl/sram_arb_ctrl.sv | 153 +++++++++++++++
 tb/tb_sram_arb_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arb_if.sv
// Request/response bundle for the two requesters of sram_arb_ctrl:
// P0 (instruction fetch) and P1 (load/store).
interface sram_arb_if #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 32,
    parameter int NUM_BYTE = 4
) ();
    logic                p0_req_valid;
    logic                p0_req_ready;
    logic                p0_req_we;
    logic [NUM_BYTE-1:0] p0_req_be;
    logic [ADDR_W-1:0]   p0_req_addr;
    logic [DATA_W-1:0]   p0_req_wdata;
    logic                p0_rsp_valid;
    logic [DATA_W-1:0]   p0_rsp_rdata;

    logic                p1_req_valid;
    logic                p1_req_ready;
    logic                p1_req_we;
    logic [NUM_BYTE-1:0] p1_req_be;
    logic [ADDR_W-1:0]   p1_req_addr;
    logic [DATA_W-1:0]   p1_req_wdata;
    logic                p1_rsp_valid;
    logic [DATA_W-1:0]   p1_rsp_rdata;

    modport master (
        output p0_req_valid, p0_req_we, p0_req_be, p0_req_addr, p0_req_wdata,
        input  p0_req_ready, p0_rsp_valid, p0_rsp_rdata,
        output p1_req_valid, p1_req_we, p1_req_be, p1_req_addr, p1_req_wdata,
        input  p1_req_ready, p1_rsp_valid, p1_rsp_rdata
    );

    modport slave (
        input  p0_req_valid, p0_req_we, p0_req_be, p0_req_addr, p0_req_wdata,
        output p0_req_ready, p0_rsp_valid, p0_rsp_rdata,
        input  p1_req_valid, p1_req_we, p1_req_be, p1_req_addr, p1_req_wdata,
        output p1_req_ready, p1_rsp_valid, p1_rsp_rdata
    );
endinterface

// File: rtl/sram_arb_ctrl.sv
// Round-robin two-port arbiter and registered pin sequencer for the TS1DA32KX32 SRAM macro.
// Define SRAM_ARB_SCRUB_EN to zero-fill the array after every reset before serving requests.
module sram_arb_ctrl #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 32,
    parameter int NUM_BYTE = 4,
    parameter int DEPTH    = 32768
) (
    input  logic                clk,
    input  logic                rst_n,
    sram_arb_if.slave           bus,
    output logic [ADDR_W-1:0]   sram_a,
    output logic                sram_ceb,
    output logic                sram_oeb,
    output logic                sram_gweb,
    output logic                sram_bweb,
    output logic [NUM_BYTE-1:0] sram_bwb,
    output logic [DATA_W-1:0]   sram_din,
    input  logic [DATA_W-1:0]   sram_dout,
    output logic                init_done
);
    localparam logic [NUM_BYTE-1:0] BWB_NONE  = '1;
    localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(DEPTH - 1);

    // {ceb, gweb, bweb, bwb} for an accepted request
    function automatic logic [NUM_BYTE+2:0] pin_ctrl(input logic we, input logic [NUM_BYTE-1:0] be);
        if (!we)           return {3'b011, BWB_NONE};
        else if (be == '0) return {3'b111, BWB_NONE};
        else if (&be)      return {3'b001, BWB_NONE};
        else               return {3'b010, ~be};
    endfunction

    logic                run;
    logic                scrub_wr;
    logic [ADDR_W-1:0]   scrub_addr;
    logic                ptr_q;
    logic                gnt0, gnt1, acc;
    logic                sel_we;
    logic [NUM_BYTE-1:0] sel_be;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                vld_p0, port_p0, rd_p0;
    logic                vld_p1, port_p1, rd_p1;

`ifdef SRAM_ARB_SCRUB_EN
    typedef enum logic {SCRUB, RUN} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] scrub_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SCRUB;
            scrub_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == SCRUB) scrub_cnt_q <= scrub_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        scrub_wr = 1'b0;
        if (state_q == SCRUB) begin
            scrub_wr = 1'b1;
            if (scrub_cnt_q == LAST_ADDR) state_d = RUN;
        end
    end

    assign scrub_addr = scrub_cnt_q;
    assign run        = (state_q == RUN);
`else
    logic run_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run_q <= 1'b0;
        else        run_q <= 1'b1;
    end

    assign scrub_wr   = 1'b0;
    assign scrub_addr = LAST_ADDR & '0;
    assign run        = run_q;
`endif

    assign init_done = run;

    // Grant depends only on the valids and the pointer, never on the payload
    always_comb begin
        gnt0             = bus.p0_req_valid & (~bus.p1_req_valid | ~ptr_q);
        gnt1             = bus.p1_req_valid & (~bus.p0_req_valid |  ptr_q);
        bus.p0_req_ready = run & gnt0;
        bus.p1_req_ready = run & gnt1;
        acc              = bus.p0_req_ready | bus.p1_req_ready;
        sel_we           = bus.p1_req_ready ? bus.p1_req_we    : bus.p0_req_we;
        sel_be           = bus.p1_req_ready ? bus.p1_req_be    : bus.p0_req_be;
        sel_addr         = bus.p1_req_ready ? bus.p1_req_addr  : bus.p0_req_addr;
        sel_wdata        = bus.p1_req_ready ? bus.p1_req_wdata : bus.p0_req_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   ptr_q <= 1'b0;
        else if (acc) ptr_q <= bus.p0_req_ready;
    end

    // Stage p0: macro pins and tag registered on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_a   <= '0;
            sram_din <= '0;
            sram_oeb <= 1'b1;
            {sram_ceb, sram_gweb, sram_bweb, sram_bwb} <= {3'b111, BWB_NONE};
        end else begin
            sram_oeb <= 1'b0;
            if (scrub_wr) begin
                sram_a   <= scrub_addr;
                sram_din <= '0;
                {sram_ceb, sram_gweb, sram_bweb, sram_bwb} <= {3'b001, BWB_NONE};
            end else if (acc) begin
                sram_a   <= sel_addr;
                sram_din <= sel_wdata;
                {sram_ceb, sram_gweb, sram_bweb, sram_bwb} <= pin_ctrl(sel_we, sel_be);
            end else begin
                {sram_ceb, sram_gweb, sram_bweb, sram_bwb} <= {3'b111, BWB_NONE};
            end
        end
    end

    // Stage p1: tag follows the macro sampling edge; response captured from DOUT one edge later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0           <= 1'b0;
            port_p0          <= 1'b0;
            rd_p0            <= 1'b0;
            vld_p1           <= 1'b0;
            port_p1          <= 1'b0;
            rd_p1            <= 1'b0;
            bus.p0_rsp_valid <= 1'b0;
            bus.p1_rsp_valid <= 1'b0;
            bus.p0_rsp_rdata <= '0;
            bus.p1_rsp_rdata <= '0;
        end else begin
            vld_p0           <= acc;
            port_p0          <= bus.p1_req_ready;
            rd_p0            <= ~sel_we;
            vld_p1           <= vld_p0;
            port_p1          <= port_p0;
            rd_p1            <= rd_p0;
            bus.p0_rsp_valid <= vld_p1 & ~port_p1;
            bus.p1_rsp_valid <= vld_p1 &  port_p1;
            if (vld_p1 & ~port_p1) bus.p0_rsp_rdata <= rd_p1 ? sram_dout : '0;
            if (vld_p1 &  port_p1) bus.p1_rsp_rdata <= rd_p1 ? sram_dout : '0;
        end
    end
endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Directed bench for sram_arb_ctrl with a behavioural model of the synchronous SRAM macro.
module tb_sram_arb_ctrl;
    localparam int ADDR_W   = 15;
    localparam int DATA_W   = 32;
    localparam int NUM_BYTE = 4;
    localparam int DEPTH    = 32768;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [ADDR_W-1:0]   sram_a;
    logic                sram_ceb, sram_oeb, sram_gweb, sram_bweb;
    logic [NUM_BYTE-1:0] sram_bwb;
    logic [DATA_W-1:0]   sram_din;
    logic [DATA_W-1:0]   sram_dout = '0;
    logic                init_done;

    int checks = 0;
    int errors = 0;

    sram_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_BYTE(NUM_BYTE)) bus ();

    sram_arb_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_BYTE(NUM_BYTE), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .sram_a    (sram_a),
        .sram_ceb  (sram_ceb),
        .sram_oeb  (sram_oeb),
        .sram_gweb (sram_gweb),
        .sram_bweb (sram_bweb),
        .sram_bwb  (sram_bwb),
        .sram_din  (sram_din),
        .sram_dout (sram_dout),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    // Macro model: full write on GWEB, byte write on BWEB/BWB, otherwise read into DOUT
    logic [DATA_W-1:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (!sram_ceb) begin
            if (!sram_gweb) mem[sram_a] <= sram_din;
            else if (!sram_bweb) begin
                for (int b = 0; b < NUM_BYTE; b++)
                    if (!sram_bwb[b]) mem[sram_a][8*b +: 8] <= sram_din[8*b +: 8];
            end else sram_dout <= mem[sram_a];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus.p0_req_valid = 1'b0; bus.p0_req_we = 1'b0; bus.p0_req_be = '0;
        bus.p0_req_addr  = '0;   bus.p0_req_wdata = '0;
        bus.p1_req_valid = 1'b0; bus.p1_req_we = 1'b0; bus.p1_req_be = '0;
        bus.p1_req_addr  = '0;   bus.p1_req_wdata = '0;
    endtask

    task automatic drive(input bit port, input logic we, input logic [3:0] be,
                         input logic [14:0] addr, input logic [31:0] wdata);
        if (!port) begin
            bus.p0_req_valid = 1'b1; bus.p0_req_we = we; bus.p0_req_be = be;
            bus.p0_req_addr  = addr; bus.p0_req_wdata = wdata;
        end else begin
            bus.p1_req_valid = 1'b1; bus.p1_req_we = we; bus.p1_req_be = be;
            bus.p1_req_addr  = addr; bus.p1_req_wdata = wdata;
        end
    endtask

    task automatic chk_idle_pins(input string tag);
        chk({tag, "_ceb"}, sram_ceb, 1'b1);
        chk({tag, "_gweb"}, sram_gweb, 1'b1);
        chk({tag, "_bweb"}, sram_bweb, 1'b1);
        chk({tag, "_bwb"}, sram_bwb, 4'hF);
    endtask

    initial begin
        idle_all();
        // Reset with P0 requesting: nothing may be granted
        bus.p0_req_valid = 1'b1;
        repeat (2) tick();
        chk_idle_pins("rst");
        chk("rst_oeb", sram_oeb, 1'b1);
        chk("rst_a", sram_a, 15'h0);
        chk("rst_din", sram_din, 32'h0);
        chk("rst_rdy0", bus.p0_req_ready, 1'b0);
        chk("rst_rdy1", bus.p1_req_ready, 1'b0);
        chk("rst_rsp0", bus.p0_rsp_valid, 1'b0);
        chk("rst_rsp1", bus.p1_rsp_valid, 1'b0);
        chk("rst_rdata0", bus.p0_rsp_rdata, 32'h0);
        chk("rst_init", init_done, 1'b0);
        idle_all();
        @(negedge clk) rst_n = 1'b1;

`ifdef SRAM_ARB_SCRUB_EN
        begin
            int cyc;
            cyc = 0;
            drive(1'b0, 1'b0, 4'h0, 15'h4000, 32'h0);
            tick(); cyc++;
            chk("scrub_gweb", sram_gweb, 1'b0);
            chk("scrub_din", sram_din, 32'h0);
            while (!init_done && cyc < 40000) begin
                chk("scrub_rdy0", bus.p0_req_ready, 1'b0);
                tick(); cyc++;
            end
            chk("scrub_init_bound", (cyc >= DEPTH) && (cyc <= DEPTH + 1), 1'b1);
            chk("scrub_rdy0_run", bus.p0_req_ready, 1'b1);
            tick();
            idle_all();
            tick();
            chk("scrub_rsp0", bus.p0_rsp_valid, 1'b0);
            tick();
            chk("scrub_rsp0_v", bus.p0_rsp_valid, 1'b1);
            chk("scrub_rd4000", bus.p0_rsp_rdata, 32'h0);
            tick();
        end
`else
        tick();
        chk("run_init", init_done, 1'b1);
        chk("run_oeb", sram_oeb, 1'b0);
        chk("run_ceb", sram_ceb, 1'b1);
        chk("run_rsp1", bus.p1_rsp_valid, 1'b0);
`endif

        // P1 full write then back-to-back read of the same address
        drive(1'b1, 1'b1, 4'hF, 15'h0123, 32'hDEADBEEF);
        #1;
        chk("a_rdy1", bus.p1_req_ready, 1'b1);
        chk("a_rdy0", bus.p0_req_ready, 1'b0);
        tick();
        chk("a_wr_ceb", sram_ceb, 1'b0);
        chk("a_wr_gweb", sram_gweb, 1'b0);
        chk("a_wr_bweb", sram_bweb, 1'b1);
        chk("a_wr_bwb", sram_bwb, 4'hF);
        chk("a_wr_a", sram_a, 15'h0123);
        chk("a_wr_din", sram_din, 32'hDEADBEEF);
        drive(1'b1, 1'b0, 4'h0, 15'h0123, 32'h0);
        #1;
        chk("a_rd_rdy1", bus.p1_req_ready, 1'b1);
        tick();
        idle_all();
        chk("a_rd_ceb", sram_ceb, 1'b0);
        chk("a_rd_gweb", sram_gweb, 1'b1);
        chk("a_rd_bweb", sram_bweb, 1'b1);
        chk("a_rsp_early", bus.p1_rsp_valid, 1'b0);
        tick();
        chk("a_wr_rsp", bus.p1_rsp_valid, 1'b1);
        chk("a_wr_rdata", bus.p1_rsp_rdata, 32'h0);
        chk("a_wr_rsp0", bus.p0_rsp_valid, 1'b0);
        chk_idle_pins("a_idle");
        chk("a_hold_a", sram_a, 15'h0123);
        tick();
        chk("a_rd_rsp", bus.p1_rsp_valid, 1'b1);
        chk("a_rd_rdata", bus.p1_rsp_rdata, 32'hDEADBEEF);
        tick();
        chk("a_rsp_pulse", bus.p1_rsp_valid, 1'b0);

        // P0 full write, partial write over it, then readback
        drive(1'b0, 1'b1, 4'hF, 15'h7FFF, 32'hDEADBEEF);
        tick();
        drive(1'b0, 1'b1, 4'b0101, 15'h7FFF, 32'h11223344);
        tick();
        chk("b_pw_ceb", sram_ceb, 1'b0);
        chk("b_pw_gweb", sram_gweb, 1'b1);
        chk("b_pw_bweb", sram_bweb, 1'b0);
        chk("b_pw_bwb", sram_bwb, 4'b1010);
        drive(1'b0, 1'b0, 4'h0, 15'h7FFF, 32'h0);
        tick();
        idle_all();
        chk("b_rsp_fw", bus.p0_rsp_valid, 1'b1);
        tick();
        chk("b_rsp_pw", bus.p0_rsp_valid, 1'b1);
        chk("b_rsp_pw_data", bus.p0_rsp_rdata, 32'h0);
        tick();
        chk("b_rsp_rd", bus.p0_rsp_valid, 1'b1);
        chk("b_rd_data", bus.p0_rsp_rdata, 32'hDE22BE44);

        // P1 write with no byte enables: no macro access, still acknowledged
        drive(1'b1, 1'b1, 4'h0, 15'h0123, 32'hFFFFFFFF);
        #1;
        chk("c_rdy1", bus.p1_req_ready, 1'b1);
        tick();
        idle_all();
        chk("c_ceb", sram_ceb, 1'b1);
        tick();
        tick();
        chk("c_ack", bus.p1_rsp_valid, 1'b1);
        chk("c_ack_rdata", bus.p1_rsp_rdata, 32'h0);
        tick();
        tick();

        // Both ports valid for four grants: P0, P1, P0, P1 with routed responses
        drive(1'b0, 1'b0, 4'h0, 15'h7FFF, 32'h0);
        drive(1'b1, 1'b0, 4'h0, 15'h0123, 32'h0);
        for (int i = 0; i <= 6; i++) begin
            if (i == 4) idle_all();
            if (i < 4) begin
                #1;
                chk($sformatf("d_rdy0_%0d", i), bus.p0_req_ready, (i % 2) == 0);
                chk($sformatf("d_rdy1_%0d", i), bus.p1_req_ready, (i % 2) == 1);
            end
            if (i >= 3) begin
                chk($sformatf("d_rsp0_%0d", i), bus.p0_rsp_valid, (i % 2) == 1);
                chk($sformatf("d_rsp1_%0d", i), bus.p1_rsp_valid, (i % 2) == 0);
                if (i % 2 == 1) chk($sformatf("d_rdata0_%0d", i), bus.p0_rsp_rdata, 32'hDE22BE44);
                else            chk($sformatf("d_rdata1_%0d", i), bus.p1_rsp_rdata, 32'hDEADBEEF);
            end
            tick();
        end
        tick();

        // Reset with a read in flight: pins idle at once, no response later
        drive(1'b0, 1'b0, 4'h0, 15'h0123, 32'h0);
        #1;
        chk("e_rdy0", bus.p0_req_ready, 1'b1);
        tick();
        idle_all();
        chk("e_issued_ceb", sram_ceb, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_idle_pins("e_rst");
        chk("e_rst_a", sram_a, 15'h0);
        chk("e_rst_oeb", sram_oeb, 1'b1);
        chk("e_rst_init", init_done, 1'b0);
        tick();
        chk("e_rsp_a", bus.p0_rsp_valid, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("e_rsp_%0d", i), bus.p0_rsp_valid, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
